// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner: column strobing, 2-flop row sync, debounce, one-cycle key strobe.
// Optional auto-repeat while a key is held is compiled in when KEY_REPEAT_EN is defined.
module key_matrix_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DLY   = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [SW-1:0] slot_cnt;
  logic          tick;
  logic [1:0]    col_idx;
  logic [1:0]    key_row;
  logic [1:0]    key_col;
  logic [1:0]    low_row;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_next;
  logic          hit;
  logic          rep_fire;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m    <= 4'hF;
      row_s    <= 4'hF;
      slot_cnt <= '0;
    end else begin
      row_m    <= row;
      row_s    <= row_m;
      slot_cnt <= tick ? '0 : slot_cnt + SW'(1);
    end
  end

  assign tick     = (slot_cnt == SLOT_LAST);
  assign deb_next = deb_cnt + DW'(1);
  assign hit      = ~row_s[key_row];

  // NOTE: a complete case with a default keeps this purely combinational;
  // a missing branch here would infer a latch.
  always_comb begin
    casez (row_s)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      default: low_row = 2'd3;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DLY);

  logic [RW-1:0] rep_cnt;

  // Anything other than a low sample in HOLD clears the count, which covers
  // entry to HOLD from either side and entry to RELEASE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (tick) begin
      if (state == HOLD && hit) rep_cnt <= rep_fire ? '0 : rep_cnt + RW'(1);
      else                      rep_cnt <= '0;
    end
  end

  assign rep_fire = tick && (state == HOLD) && hit && (rep_cnt + RW'(1) == REP_LAST);
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= 4'b1110;
      col_idx   <= '0;
      key_row   <= '0;
      key_col   <= '0;
      deb_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (row_s != 4'hF) begin
              key_row <= low_row;
              key_col <= col_idx;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col     <= {col[2:0], col[3]};
              col_idx <= col_idx + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (hit) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_LAST) begin
                key_code  <= {key_row, key_col};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                state     <= HOLD;
              end
            end else begin
              state   <= SCAN;
              col     <= {col[2:0], col[3]};
              col_idx <= col_idx + 2'd1;
            end
          end
          HOLD: begin
            if (!hit) begin
              deb_cnt <= '0;
              state   <= RELEASE;
            end else if (rep_fire) begin
              key_valid <= 1'b1;
            end
          end
          RELEASE: begin
            if (!hit) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_LAST) begin
                key_down <= 1'b0;
                state    <= SCAN;
                col      <= {col[2:0], col[3]};
                col_idx  <= col_idx + 2'd1;
              end
            end else begin
              deb_cnt <= '0;
              state   <= HOLD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan: a physical 4x4 matrix model drives row from col,
// and a slot-level behavioural model predicts col/key_code/key_valid/key_down every cycle.
module tb_key_matrix_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = '0;

  int errors  = 0;
  int checks  = 0;
  int strobes = 0;

  // Behavioural model: key index = r*4 + c, counters of consecutive agreeing samples.
  int m_slot, m_col, m_code, trk_r, trk_c, low_run, high_run, rep_run;
  bit m_valid, m_down, m_locked, m_ticked;

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  key_matrix_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEB)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DLY  (REP)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] col_vec(input int c);
    return ~(4'b0001 << c);
  endfunction

  function automatic logic [3:0] seen_rows(input int c);
    logic [3:0] v = 4'hF;
    for (int r = 0; r < 4; r++) if (keys[r*4+c]) v[r] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_slot = 0; m_col = 0; m_code = 0; m_valid = 0; m_down = 0; m_locked = 0;
    trk_r = 0; trk_c = 0; low_run = 0; high_run = 0; rep_run = 0; m_ticked = 0;
  endtask

  task automatic model_tick();
    logic [3:0] v;
    bit pressed;
    if (!m_locked) begin
      v = seen_rows(m_col);
      if (v != 4'hF) begin
        m_locked = 1;
        trk_c    = m_col;
        for (int r = 3; r >= 0; r--) if (!v[r]) trk_r = r;
        low_run  = 0;
      end else begin
        m_col = (m_col + 1) % 4;
      end
    end else begin
      pressed = keys[trk_r*4+trk_c];
      if (!m_down) begin
        if (pressed) begin
          low_run++;
          if (low_run == DEB) begin
            m_code = trk_r*4 + trk_c; m_valid = 1; m_down = 1; high_run = 0; rep_run = 0;
          end
        end else begin
          m_locked = 0;
          m_col    = (m_col + 1) % 4;
        end
      end else if (pressed) begin
        if (high_run > 0) begin
          high_run = 0; rep_run = 0;
        end else begin
          rep_run++;
`ifdef KEY_REPEAT_EN
          if (rep_run == REP) begin m_valid = 1; rep_run = 0; end
`endif
        end
      end else begin
        high_run++; rep_run = 0;
        if (high_run == DEB + 1) begin
          m_down = 0; m_locked = 0; m_col = (m_col + 1) % 4;
        end
      end
    end
  endtask

  task automatic model_edge();
    m_valid  = 0;
    m_ticked = (m_slot == SCAN_DIV - 1);
    if (m_ticked) begin
      m_slot = 0;
      model_tick();
    end else begin
      m_slot++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check("col",       32'(col),       32'(col_vec(m_col)));
    check("key_code",  32'(key_code),  32'(m_code));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_down",  32'(key_down),  32'(m_down));
    if (key_valid === 1'b1) strobes++;
  endtask

  task automatic run_ticks(input int n);
    int t = 0;
    while (t < n) begin
      step();
      if (m_ticked) t++;
    end
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = (key_valid === 1'b1);
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r;
    int exp_rep;

    // Reset held two cycles with an idle matrix.
    rst = 1'b1; keys = '0;
    step(); step();
    check("rst_col",       32'(col),       32'h0000_000E);
    check("rst_key_code",  32'(key_code),  32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_down",  32'(key_down),  32'd0);
    rst = 1'b0;
    run_ticks(4);
    check("idle_wrap_col", 32'(col), 32'h0000_000E);

    // Clean press of row 2 / col 1.
    s0 = strobes; keys = 16'h1 << 9;
    run_ticks(8);
    check("clean_code",    32'(key_code), 32'd9);
    check("clean_down",    32'(key_down), 32'd1);
    check("clean_col",     32'(col),      32'h0000_000D);
    check("clean_strobes", 32'(strobes - s0), 32'd1);
    keys = '0;
    run_ticks(4);
    check("release_down", 32'(key_down), 32'd0);
    check("release_col",  32'(col),      32'h0000_000B);
    check("release_code", 32'(key_code), 32'd9);

    // Bounce: row 0 low on the detecting tick only.
    s0 = strobes; keys = 16'h1 << 2;
    run_ticks(1);
    keys = '0;
    run_ticks(1);
    check("bounce_col",     32'(col),          32'h0000_0007);
    check("bounce_code",    32'(key_code),     32'd9);
    check("bounce_strobes", 32'(strobes - s0), 32'd0);

    // Release glitch: one high tick into RELEASE, then low again.
    s0 = strobes; keys = 16'h1 << 3;
    run_ticks(4);
    keys = '0;
    run_ticks(2);
    keys = 16'h1 << 3;
    run_ticks(1);
    check("glitch_down",    32'(key_down),     32'd1);
    check("glitch_strobes", 32'(strobes - s0), 32'd1);
    keys = '0;
    run_ticks(4);
    check("glitch_rel_down", 32'(key_down), 32'd0);
    check("glitch_rel_col",  32'(col),      32'h0000_000E);

    // Two rows low in col 0, then a second key in col 2 while held.
    s0 = strobes; keys = (16'h1 << 4) | (16'h1 << 12);
    run_ticks(4);
    keys = keys | (16'h1 << 10);
    run_ticks(2);
    check("two_code",    32'(key_code),     32'd4);
    check("two_col",     32'(col),          32'h0000_000E);
    check("two_strobes", 32'(strobes - s0), 32'd1);
    keys = '0;
    run_ticks(4);

    // Reset mid-press: outputs clear, the held key is re-detected.
    keys = 16'h1 << 9;
    run_ticks(4);
    rst = 1'b1;
    step();
    check("midrst_col",  32'(col),      32'h0000_000E);
    check("midrst_code", 32'(key_code), 32'd0);
    check("midrst_down", 32'(key_down), 32'd0);
    rst = 1'b0;
    s0 = strobes;
    run_ticks(6);
    check("redetect_code",    32'(key_code),     32'd9);
    check("redetect_strobes", 32'(strobes - s0), 32'd1);
    keys = '0;
    run_ticks(4);

    // Long hold of key 3: repeats every REP ticks only when the feature is built in.
    s0 = strobes; keys = 16'h1 << 3;
    wait_strobe("hold_first_strobe", 200);
    run_ticks(12);
`ifdef KEY_REPEAT_EN
    exp_rep = 1 + 12 / REP;
`else
    exp_rep = 1;
`endif
    check("hold_code",    32'(key_code),     32'd3);
    check("hold_strobes", 32'(strobes - s0), 32'(exp_rep));
    keys = '0;
    run_ticks(4);

    // Random key activity, changed only just after a tick, with occasional resets.
    for (int i = 0; i < 500; i++) begin
      run_ticks(1);
      r = int'($urandom_range(0, 31));
      if (r < 5)        keys = '0;
      else if (r < 8)   keys = 16'h1 << $urandom_range(0, 15);
      else if (r == 8)  keys = keys | (16'h1 << $urandom_range(0, 15));
      else if (r == 31) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
